// File: rtl/tff_meter_pkg.sv
// Shared types and limits for the toggle period meter.
package tff_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS_HI,
        MEAS_LO
    } state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Keeps the synchronizer depth inside the supported range.
    function automatic int unsigned sync_depth(input int unsigned req);
        if (req < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (req > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return req;
    endfunction

endpackage

// File: rtl/tff_period_meter_if.sv
// Result port of the period meter: valid/ready with period, high time and timeout tag.
interface tff_period_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             O_VALID;
    logic             O_READY;
    logic [CNT_W-1:0] O_PERIOD;
    logic [CNT_W-1:0] O_HIGH;
    logic             O_TIMEOUT;

    modport master (
        output O_VALID,
        output O_PERIOD,
        output O_HIGH,
        output O_TIMEOUT,
        input  O_READY
    );

    modport slave (
        input  O_VALID,
        input  O_PERIOD,
        input  O_HIGH,
        input  O_TIMEOUT,
        output O_READY
    );
endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into CLK and produces single-cycle edge pulses.
module sync_edge_det
    import tff_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    localparam int unsigned DEPTH = sync_depth(SYNC_STAGES);

    logic [DEPTH-1:0] sync;
    logic             hist;

    // Synchronizer chain followed by one history flop for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[DEPTH-2:0], D};
            hist <= sync[DEPTH-1];
        end
    end

    assign LEVEL = sync[DEPTH-1];
    assign RISE  = sync[DEPTH-1] & ~hist;
    assign FALL  = ~sync[DEPTH-1] & hist;

endmodule

// File: rtl/tff_period_meter.sv
// Measures high time and period of a toggling input in CLK cycles and
// hands each measurement (or timeout record) out through a one-deep result register.
module tff_period_meter
    import tff_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                T_IN,
    input  logic                EN,
    tff_period_meter_if.master  res,
    output logic                O_OVF
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic             timeout;
    } result_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             level;
    logic             rise;
    logic             fall;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] hi_n;
    logic             emit;
    result_t          emit_res;

    result_t          held;
    logic             valid;
    logic             ovf;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .D     (T_IN),
        .LEVEL (level),
        .RISE  (rise),
        .FALL  (fall)
    );

    // State, running counter and captured high time.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
        end
    end

    // Next-state, counter updates and result emission.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_n     = hi;
        emit     = 1'b0;
        emit_res = '0;
        if (!EN) begin
            state_n = IDLE;
            cnt_n   = '0;
            hi_n    = '0;
        end else begin
            unique case (state)
                IDLE: state_n = ARM;
                ARM: begin
                    if (rise && level) begin
                        state_n = MEAS_HI;
                        cnt_n   = CNT_ONE;
                        hi_n    = '0;
                    end
                end
                MEAS_HI: begin
                    if (fall) begin
                        state_n = MEAS_LO;
                        hi_n    = cnt;
                        cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        emit     = 1'b1;
                        emit_res = '{period: CNT_MAX, high: '0, timeout: 1'b1};
                        state_n  = ARM;
                        cnt_n    = '0;
                        hi_n     = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                MEAS_LO: begin
                    // The closing rise also opens the next period, so measurement is gapless.
                    if (rise) begin
                        emit     = 1'b1;
                        emit_res = '{period: cnt, high: hi, timeout: 1'b0};
                        state_n  = MEAS_HI;
                        cnt_n    = CNT_ONE;
                        hi_n     = '0;
                    end else if (cnt == CNT_MAX) begin
                        emit     = 1'b1;
                        emit_res = '{period: CNT_MAX, high: hi, timeout: 1'b1};
                        state_n  = ARM;
                        cnt_n    = '0;
                        hi_n     = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // One-deep result holding register with sticky overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            held  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (emit) begin
                if (!valid || res.O_READY) begin
                    held  <= emit_res;
                    valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (valid && res.O_READY) begin
                valid <= 1'b0;
            end
            if (!EN) begin
                ovf <= 1'b0;
            end
        end
    end

    assign res.O_VALID   = valid;
    assign res.O_PERIOD  = held.period;
    assign res.O_HIGH    = held.high;
    assign res.O_TIMEOUT = held.timeout;
    assign O_OVF         = ovf;

endmodule
